// File: rtl/cpu_run_control_if.sv
// Front-panel and CPU-side signal bundle for cpu_run_control.
// The panel/CPU side drives the i_* signals and the controller drives the o_* signals.
interface cpu_run_control_if;
    logic       i_btn_start;
    logic       i_btn_step;
    logic       i_sw_step_mode;
    logic       i_instr_transmit_done;
    logic       i_halt;
    logic       o_start_cpu;
    logic       o_step_execution;
    logic       o_cpu_en;
    logic [1:0] o_state;

    modport master (
        output i_btn_start, i_btn_step, i_sw_step_mode, i_instr_transmit_done, i_halt,
        input  o_start_cpu, o_step_execution, o_cpu_en, o_state
    );

    modport slave (
        input  i_btn_start, i_btn_step, i_sw_step_mode, i_instr_transmit_done, i_halt,
        output o_start_cpu, o_step_execution, o_cpu_en, o_state
    );
endinterface

// File: rtl/cpu_run_control.sv
// Front-panel run controller: button/switch conditioning plus the load/ready/run/halt lifecycle.
// Define RUN_CTRL_SKIP_DEBOUNCE_EN to bypass the debounce counters (sync + edge detect only).
module cpu_run_control #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    cpu_run_control_if.slave bus
);

    typedef enum logic [1:0] {
        S_WAIT_LOAD = 2'b00,
        S_READY     = 2'b01,
        S_RUN       = 2'b10,
        S_HALTED    = 2'b11
    } state_t;

    localparam int NIN = 3;

    // Bit 0 = start button, bit 1 = step button, bit 2 = step-mode switch.
    logic [NIN-1:0] w_raw;
    logic [NIN-1:0] r_sync1;
    logic [NIN-1:0] r_sync2;
    logic [NIN-1:0] w_deb;
    logic [1:0]     r_btn_prev;
    logic [1:0]     r_btn_pls;
    logic           r_step_mode;
    logic           w_start_pls;
    logic           w_step_pls;
    state_t         r_state;
    logic           r_start_cpu;
    logic           r_cpu_en;

    assign w_raw = {bus.i_sw_step_mode, bus.i_btn_step, bus.i_btn_start};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef RUN_CTRL_SKIP_DEBOUNCE_EN
    assign w_deb = r_sync2;
`else
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NIN-1:0] r_deb;
    logic [CNT_W-1:0] r_cnt [NIN];

    // Any sample that agrees with the current level restarts the count, so bounce never accumulates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_deb <= '0;
            for (int i = 0; i < NIN; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_deb = r_deb;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_prev  <= '0;
            r_btn_pls   <= '0;
            r_step_mode <= 1'b0;
        end else begin
            r_btn_prev  <= w_deb[1:0];
            r_btn_pls   <= w_deb[1:0] & ~r_btn_prev;
            r_step_mode <= w_deb[2];
        end
    end

    assign w_start_pls = r_btn_pls[0];
    assign w_step_pls  = r_btn_pls[1];

    // Outputs are rebuilt every cycle; o_start_cpu and step-mode o_cpu_en are single-cycle strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_WAIT_LOAD;
            r_start_cpu <= 1'b0;
            r_cpu_en    <= 1'b0;
        end else begin
            r_start_cpu <= 1'b0;
            r_cpu_en    <= 1'b0;
            case (r_state)
                S_WAIT_LOAD: begin
                    if (bus.i_instr_transmit_done) r_state <= S_READY;
                end
                S_READY: begin
                    if (w_start_pls) begin
                        r_state     <= S_RUN;
                        r_start_cpu <= 1'b1;
                        r_cpu_en    <= ~r_step_mode;
                    end
                end
                S_RUN: begin
                    if (bus.i_halt) r_state <= S_HALTED;
                    else            r_cpu_en <= ~r_step_mode | w_step_pls;
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
            endcase
        end
    end

    assign bus.o_start_cpu      = r_start_cpu;
    assign bus.o_step_execution = r_step_mode;
    assign bus.o_cpu_en         = r_cpu_en;
    assign bus.o_state          = r_state;

endmodule

// File: tb/tb_cpu_run_control.sv
// Bench for cpu_run_control: directed front-panel scenarios plus random stimulus,
// checked every cycle against a sample-window model of the panel controller.
module tb_cpu_run_control;

  localparam int D = 4;

  logic i_clk;
  logic i_rst_n;
  cpu_run_control_if bus();

  cpu_run_control #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_checks;
  int n_fail;
  bit chk_en;
  int start_cnt;
  int en_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: a debounced level flips once the last D synchronised samples all disagree with it
  logic [2:0] raw_q[$];
  logic [2:0] m_deb, m_deb_prev;
  logic [1:0] m_pls;
  logic       m_mode;
  int         m_state;
  logic       m_start, m_en;

  task automatic model_reset();
    raw_q.delete();
    for (int i = 0; i < D + 2; i++) raw_q.push_back(3'b000);
    m_deb = '0; m_deb_prev = '0; m_pls = '0; m_mode = 1'b0;
    m_state = 0; m_start = 1'b0; m_en = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] nd;
    logic [1:0] pls_in;
    logic       mode_in;
    int         sz;
    raw_q.push_back({bus.i_sw_step_mode, bus.i_btn_step, bus.i_btn_start});
    if (raw_q.size() > D + 2) void'(raw_q.pop_front());
    sz = raw_q.size();
`ifdef RUN_CTRL_SKIP_DEBOUNCE_EN
    nd = raw_q[sz-2];
`else
    for (int b = 0; b < 3; b++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int j = 2; j <= D + 1; j++)
        if (raw_q[sz-1-j][b] == m_deb[b]) all_diff = 1'b0;
      nd[b] = all_diff ? ~m_deb[b] : m_deb[b];
    end
`endif
    pls_in     = m_pls;
    mode_in    = m_mode;
    m_pls      = m_deb[1:0] & ~m_deb_prev[1:0];
    m_mode     = m_deb[2];
    m_deb_prev = m_deb;
    m_deb      = nd;
    m_start    = 1'b0;
    m_en       = 1'b0;
    case (m_state)
      0: if (bus.i_instr_transmit_done) m_state = 1;
      1: if (pls_in[0]) begin m_state = 2; m_start = 1'b1; m_en = !mode_in; end
      2: if (bus.i_halt) m_state = 3; else m_en = !mode_in || pls_in[1];
      default: ;
    endcase
  endtask

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) model_reset();
    else          model_step();
  end

  // scoreboard compare, one sample per cycle away from the active edge
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("state",     bus.o_state,          m_state[1:0]);
      check("start_cpu", bus.o_start_cpu,      m_start);
      check("cpu_en",    bus.o_cpu_en,         m_en);
      check("step_exec", bus.o_step_execution, m_mode);
    end
    start_cnt += int'(bus.o_start_cpu);
    en_cnt    += int'(bus.o_cpu_en);
  end

  // driver tasks; inputs change 1 time unit after the falling edge
  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic press(input int which, input int hold);
    if (which == 0) bus.i_btn_start = 1'b1; else bus.i_btn_step = 1'b1;
    repeat (hold) tick();
    bus.i_btn_start = 1'b0;
    bus.i_btn_step  = 1'b0;
    repeat (10) tick();
  endtask

  task automatic load_and_run();
    bus.i_instr_transmit_done = 1'b1;
    tick();
    bus.i_instr_transmit_done = 1'b0;
    press(0, 10);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 1'b0;
    start_cnt = 0; en_cnt = 0;
    model_reset();
    i_rst_n = 1'b0;
    bus.i_btn_start = 1'b0; bus.i_btn_step = 1'b0; bus.i_sw_step_mode = 1'b0;
    bus.i_instr_transmit_done = 1'b0; bus.i_halt = 1'b0;
    repeat (3) tick();
    check("rst_state", bus.o_state, 2'b00);
    check("rst_start", bus.o_start_cpu, 1'b0);
    check("rst_en",    bus.o_cpu_en, 1'b0);
    check("rst_step",  bus.o_step_execution, 1'b0);
    chk_en = 1'b1;
    i_rst_n = 1'b1;

    // 1: bouncing start press while waiting for a load is ignored
    start_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus.i_btn_start = ((i % 2) == 0);
      tick();
    end
    press(0, 10);
    check("t1_state", bus.o_state, 2'b00);
    check("t1_start_cnt", start_cnt, 0);

    // 2: load then start in continuous mode
    bus.i_instr_transmit_done = 1'b1;
    tick();
    bus.i_instr_transmit_done = 1'b0;
    check("t2_ready", bus.o_state, 2'b01);
    start_cnt = 0;
    bus.i_btn_start = 1'b1;
    repeat (7) tick();
    check("t2_pre_run", bus.o_state, 2'b01);
    tick();
    check("t2_run", bus.o_state, 2'b10);
    check("t2_start_pulse", bus.o_start_cpu, 1'b1);
    check("t2_en_entry", bus.o_cpu_en, 1'b1);
    tick();
    check("t2_start_drop", bus.o_start_cpu, 1'b0);
    check("t2_en_hold", bus.o_cpu_en, 1'b1);
    repeat (8) tick();
    bus.i_btn_start = 1'b0;
    repeat (10) tick();
    press(0, 10);
    check("t2_start_cnt", start_cnt, 1);
    check("t2_en_still", bus.o_cpu_en, 1'b1);

    // 3: step mode, three presses give three single-cycle enables
    bus.i_sw_step_mode = 1'b1;
    repeat (10) tick();
    check("t3_mode", bus.o_step_execution, 1'b1);
    check("t3_en_idle", bus.o_cpu_en, 1'b0);
    en_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      bus.i_btn_step = 1'b1;
      repeat (7) tick();
      check("t3_en_before", bus.o_cpu_en, 1'b0);
      tick();
      check("t3_en_pulse", bus.o_cpu_en, 1'b1);
      tick();
      check("t3_en_after", bus.o_cpu_en, 1'b0);
      repeat (9) tick();
      bus.i_btn_step = 1'b0;
      repeat (10) tick();
    end
    check("t3_en_cnt", en_cnt, 3);

    // 4: back to continuous, then halt is terminal
    bus.i_sw_step_mode = 1'b0;
    repeat (10) tick();
    check("t4_en_cont", bus.o_cpu_en, 1'b1);
    bus.i_halt = 1'b1;
    tick();
    bus.i_halt = 1'b0;
    check("t4_halted", bus.o_state, 2'b11);
    check("t4_en_off", bus.o_cpu_en, 1'b0);
    start_cnt = 0; en_cnt = 0;
    press(0, 10);
    press(1, 10);
    check("t4_start_cnt", start_cnt, 0);
    check("t4_en_cnt", en_cnt, 0);
    check("t4_terminal", bus.o_state, 2'b11);

    // 5: step pulse coincident with halt
    bus.i_sw_step_mode = 1'b1;
    do_reset();
    repeat (8) tick();
    load_and_run();
    check("t5_run", bus.o_state, 2'b10);
    en_cnt = 0;
    bus.i_btn_step = 1'b1;
    repeat (7) tick();
    bus.i_halt = 1'b1;
    tick();
    bus.i_halt = 1'b0;
    check("t5_halted", bus.o_state, 2'b11);
    check("t5_en", bus.o_cpu_en, 1'b0);
    repeat (10) tick();
    bus.i_btn_step = 1'b0;
    repeat (10) tick();
    check("t5_en_cnt", en_cnt, 0);

    // 6: asynchronous reset mid-run
    bus.i_sw_step_mode = 1'b0;
    do_reset();
    repeat (8) tick();
    load_and_run();
    check("t6_run", bus.o_state, 2'b10);
    check("t6_en", bus.o_cpu_en, 1'b1);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_state", bus.o_state, 2'b00);
    check("t6_rst_en", bus.o_cpu_en, 1'b0);
    check("t6_rst_start", bus.o_start_cpu, 1'b0);
    tick();
    i_rst_n = 1'b1;
    repeat (10) tick();
    check("t6_wait", bus.o_state, 2'b00);
    bus.i_instr_transmit_done = 1'b1;
    tick();
    bus.i_instr_transmit_done = 1'b0;
    check("t6_ready", bus.o_state, 2'b01);

    // random phase
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 9) == 0)   bus.i_btn_start = ~bus.i_btn_start;
      if ($urandom_range(0, 9) == 0)   bus.i_btn_step = ~bus.i_btn_step;
      if ($urandom_range(0, 59) == 0)  bus.i_sw_step_mode = ~bus.i_sw_step_mode;
      bus.i_instr_transmit_done = ($urandom_range(0, 29) == 0);
      bus.i_halt = ($urandom_range(0, 149) == 0);
      i_rst_n = ($urandom_range(0, 499) != 0);
    end
    i_rst_n = 1'b1;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_control.md
Name: cpu_run_control

Overview:
Front-panel run controller feeding the status-LED block and the CPU core.
- Synchronises and debounces the start button, step button and step-mode switch.
- Tracks the program lifecycle: wait-for-load, ready, running, halted.
- Issues the CPU start pulse, the step-mode level and the per-cycle CPU enable.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required before a debounced level changes (10 ms at 100 MHz)
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  reset, asynchronous, active-low
i_btn_start  input  1  raw start push-button, active-high, asynchronous
i_btn_step  input  1  raw single-step push-button, active-high, asynchronous
i_sw_step_mode  input  1  raw mode switch: 1 = single-step, 0 = continuous
i_instr_transmit_done  input  1  program load complete, synchronous, sampled every cycle
i_halt  input  1  CPU executed halt, synchronous level
o_start_cpu  output  1  one-cycle pulse when READY->RUN is taken
o_step_execution  output  1  debounced step-mode level
o_cpu_en  output  1  CPU clock enable
o_state  output  2  current FSM state, for debug/LED use

Behaviour:
- Reset: all outputs 0; state S_WAIT_LOAD; synchronisers, debounced levels, edge registers and counters all 0. Reset mid-operation aborts immediately, including from S_HALTED.
- Input conditioning: each raw input passes a 2-flop synchroniser.
- Debounce, one per input:
  - The counter increments while the synchronised level differs from the debounced level.
  - It clears whenever they are equal, so any bounce restarts the count.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced level takes the new value and the counter clears.
- Edge detect: registered debounced-previous gives a one-cycle rising-edge pulse for each button. Press-to-pulse latency = 2 + DEBOUNCE_CYCLES + 1 cycles. Releases produce nothing. A held button gives exactly one pulse.
- o_step_execution = debounced switch level, registered.
- FSM (o_state encoding in brackets):
  - S_WAIT_LOAD (00): on i_instr_transmit_done, go to S_READY. Start and step pulses are ignored.
  - S_READY (01): on start pulse, go to S_RUN and assert o_start_cpu for exactly that transition cycle (registered; visible the cycle S_RUN is entered). Step pulses are ignored. A repeated i_instr_transmit_done keeps S_READY.
  - S_RUN (10), continuous mode: o_cpu_en = 1 every cycle.
  - S_RUN (10), step mode: o_cpu_en = 1 for exactly one cycle per step pulse, registered (one cycle after the pulse).
  - S_RUN (10): i_halt = 1 -> S_HALTED. o_cpu_en is 0 from the next cycle onward.
  - S_HALTED (11): terminal. o_cpu_en = 0, all button pulses ignored. Exit only via reset.
- Simultaneous events and boundary cases:
  - i_instr_transmit_done and start pulse in the same cycle in S_WAIT_LOAD: go to S_READY only; the start is lost.
  - i_halt and step pulse in the same cycle: halt wins, no enable pulse.
  - Mode switch change while in S_RUN takes effect the cycle after the debounced level changes. A step pulse pending in that cycle is discarded when switching to continuous.
  - Start pulse while already in S_RUN: ignored; o_start_cpu never re-pulses.
  - Debounce counters saturate-free by construction; no wrap can occur since the counter clears at DEBOUNCE_CYCLES-1.

Optional Feature:
Macro RUN_CTRL_SKIP_DEBOUNCE_EN.
- Defined: debounce counters are removed and the debounced level equals the synchronised level. Synchronisers and edge detectors are kept, giving press-to-pulse latency = 3 cycles. Intended for simulation and fast bring-up.
- Undefined: full debounce as above.
- DEBOUNCE_CYCLES is unused when the macro is defined.

Test Plan:
1. DEBOUNCE_CYCLES=4. Press i_btn_start with bounce pattern 1,0,1,0 then hold high 10 cycles -> exactly one internal start pulse, 7 cycles after the last rising bounce. No pulse while in S_WAIT_LOAD, o_state stays 00.
2. Reset, pulse i_instr_transmit_done, then press start (switch=0) -> o_state 00->01->10; o_start_cpu high exactly 1 cycle; o_cpu_en high continuously from S_RUN entry.
3. Switch=1 debounced, in S_RUN, press step 3 times -> exactly 3 single-cycle o_cpu_en pulses; o_cpu_en 0 between presses; holding the button yields no extra pulses.
4. In S_RUN continuous, assert i_halt for 1 cycle -> o_state=11, o_cpu_en 0 from the next cycle. Subsequent start/step presses give no o_start_cpu or o_cpu_en activity.
5. Step pulse and i_halt coincident in step mode -> o_cpu_en stays 0, o_state=11.
6. Assert i_rst_n=0 mid-S_RUN (asynchronously, between clock edges) -> all outputs 0 and o_state=00 immediately. After release, o_state stays 00 until i_instr_transmit_done is seen.
